load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 1, memory-stage access request, held by pipeline while stall=1.
REQ-004 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-005 SHALL have port req_size, input, 2, 00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
REQ-006 SHALL have port req_signed, input, 1, sign-extend sub-word loads when 1, zero-extend when 0.
REQ-007 SHALL have ports req_addr, input, 7 (byte address), and req_wdata, input, 32 (store data, right-justified).
REQ-008 SHALL have ports stall, output, 1, and done, output, 1 (completion pulse).
REQ-009 SHALL have ports rdata, output, 32 (extended load result), and misalign_err, output, 1.
REQ-010 SHALL have data-memory ports dm_R_addr, output, 7; dm_W_addr, output, 7; dm_W_data, output, 32; dm_MemRead, output, 1; dm_MemWrite, output, 1; dm_R_data, input, 32 (combinational read, write on negedge clk).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, RMW_RD, STORE, DONE.
REQ-012 SHALL, in IDLE with req_valid=1, register addr/size/signed/we/wdata and go to DONE if misaligned, LOAD if load, RMW_RD if sub-word store, STORE if word store.
REQ-013 SHALL treat as misaligned: half with addr[0]=1, word with addr[1:0]!=00, size 11.
REQ-014 SHALL drive stall = req_valid AND NOT done, combinationally.
REQ-015 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE.
REQ-016 SHALL, in LOAD, drive dm_R_addr from the registered address with dm_MemRead=1 and register the extended result into rdata at the cycle's end.
REQ-017 SHALL use little-endian lanes: byte lane = addr[1:0] (lane 0 = bits 7:0); halfword lane = addr[1] (0 = bits 15:0).
REQ-018 SHALL, in RMW_RD, read the addressed word and register it; in STORE, write it with only the addressed lane replaced by req_wdata's low byte/half.
REQ-019 SHALL, in STORE, drive dm_MemWrite=1, dm_W_addr = registered address, dm_W_data = merged or full word; dm_MemWrite SHALL be 0 in every other state.
REQ-020 SHALL complete with done at: load cycle 3, word store cycle 3, sub-word store cycle 4, misaligned cycle 2 (cycle 1 = acceptance).
REQ-021 SHALL, on misaligned requests, perform no memory access, hold rdata unchanged, and assert misalign_err during DONE only.
REQ-022 SHALL hold rdata stable from load completion until the next load's LOAD cycle.
REQ-023 SHALL ignore req_valid in all states except IDLE.
REQ-024 SHALL drive dm_MemRead=0 and dm_R_addr/dm_W_addr/dm_W_data = registered values outside LOAD/RMW_RD/STORE.

Reset
REQ-025 SHALL, on reset assertion, immediately enter IDLE, deassert dm_MemWrite/dm_MemRead/done/misalign_err, and clear rdata and all registered request fields to 0.
REQ-026 SHALL abort any in-flight access on reset mid-operation with no memory write issued after assertion; the pipeline reissues.

Configuration
REQ-027 SHALL, with LSU_SUBWORD_EN defined, support byte/halfword loads and stores as specified.
REQ-028 SHALL, without LSU_SUBWORD_EN, omit RMW_RD and extension logic and treat req_size!=10 as misaligned.

Verification
REQ-029 SHALL cover: word 0x0000000A at byte addr 0x04 initialised, load word addr 0x04 -> done in cycle 3, rdata=0x0000000A, stall high cycles 1-2.
REQ-030 SHALL cover: word 0x12345680 at 0x08, signed byte load addr 0x08 -> rdata=0xFFFFFF80; unsigned -> 0x00000080; signed half addr 0x0A -> 0x00001234.
REQ-031 SHALL cover: word 0xAABBCCDD at 0x0C, byte store 0x11 to addr 0x0D -> single dm_MemWrite pulse in cycle 3, memory word becomes 0xAABB11DD, done in cycle 4.
REQ-032 SHALL cover: word load to addr 0x06 -> misalign_err=1 and done in cycle 2, dm_MemRead/dm_MemWrite never asserted, rdata unchanged.
REQ-033 SHALL cover: reset asserted during STORE of 0xDEADBEEF to 0x10 -> dm_MemWrite drops immediately, state IDLE, memory at 0x10 unchanged.
REQ-034 SHALL cover: back-to-back word store 0x5 to 0x14 then load 0x14 -> load returns 0x00000005, second request accepted cycle after first done.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: sequences word loads/stores against a
// combinational-read data memory. Define LSU_SUBWORD_EN for byte/halfword access.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign_err,
    output logic [6:0]  dm_R_addr,
    output logic [6:0]  dm_W_addr,
    output logic [31:0] dm_W_data,
    output logic        dm_MemRead,
    output logic        dm_MemWrite,
    input  logic [31:0] dm_R_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
`ifdef LSU_SUBWORD_EN
        RMW_RD = 3'd2,
`endif
        STORE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
`ifdef LSU_SUBWORD_EN
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
`else
    logic        unused_s;
    assign unused_s = req_signed;
`endif

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
`ifdef LSU_SUBWORD_EN
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lo[0];
            2'b10:   r = (lo != 2'b00);
            default: r = 1'b1;
        endcase
`else
        r = (size != 2'b10) || (lo != 2'b00);
`endif
        return r;
    endfunction

`ifdef LSU_SUBWORD_EN
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] r;
        r = old_word;
        case (size)
            2'b00: begin
                case (lo)
                    2'b00:   r[7:0]   = wdata[7:0];
                    2'b01:   r[15:8]  = wdata[7:0];
                    2'b10:   r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (lo[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction
`endif

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef LSU_SUBWORD_EN
        size_d   = size_q;
        signed_d = signed_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
`ifdef LSU_SUBWORD_EN
                    size_d   = req_size;
                    signed_d = req_signed;
`endif
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = LOAD;
`ifdef LSU_SUBWORD_EN
                    end else if (req_size != 2'b10) begin
                        state_d = RMW_RD;
`endif
                    end else begin
                        state_d = STORE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
`ifdef LSU_SUBWORD_EN
                rdata_d = load_extend(dm_R_data, size_q, signed_q, addr_q[1:0]);
`else
                rdata_d = dm_R_data;
`endif
                state_d = DONE;
                done_d  = 1'b1;
            end
`ifdef LSU_SUBWORD_EN
            RMW_RD: begin
                wdata_d = store_merge(dm_R_data, wdata_q, size_q, addr_q[1:0]);
                state_d = STORE;
            end
`endif
            STORE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef LSU_SUBWORD_EN
        rd_d = (state_d == LOAD) || (state_d == RMW_RD);
`else
        rd_d = (state_d == LOAD);
`endif
        wr_d = (state_d == STORE) && we_d;
    end

    // State and registered-output flops; reset drops any pending write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 7'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef LSU_SUBWORD_EN
            size_q   <= 2'b00;
            signed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef LSU_SUBWORD_EN
            size_q   <= size_d;
            signed_q <= signed_d;
`endif
        end
    end

    assign stall        = req_valid & ~done_q;
    assign done         = done_q;
    assign misalign_err = err_q;
    assign rdata        = rdata_q;
    assign dm_R_addr    = addr_q;
    assign dm_W_addr    = addr_q;
    assign dm_W_data    = wdata_q;
    assign dm_MemRead   = rd_q;
    assign dm_MemWrite  = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a negedge-write data memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign_err;
    logic [6:0]  dm_R_addr;
    logic [6:0]  dm_W_addr;
    logic [31:0] dm_W_data;
    logic        dm_MemRead;
    logic        dm_MemWrite;
    logic [31:0] dm_R_data;
    logic        preload;

    logic [31:0] mem [0:31];

    int n_cmp = 0;
    int n_fail = 0;
    int r_done, r_err, r_stall, r_rd, r_wr, r_wrcyc;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
        .misalign_err(misalign_err), .dm_R_addr(dm_R_addr), .dm_W_addr(dm_W_addr),
        .dm_W_data(dm_W_data), .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
        .dm_R_data(dm_R_data)
    );

    always #5 clk = ~clk;

    assign dm_R_data = mem[dm_R_addr[6:2]];

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h0000000A;
            mem[2] <= 32'h12345680;
            mem[3] <= 32'hAABBCCDD;
            mem[4] <= 32'h12121212;
            mem[5] <= 32'hFFFFFFFF;
        end else if (dm_MemWrite) begin
            mem[dm_W_addr[6:2]] <= dm_W_data;
        end
    end

    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [6:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        r_done = 0; r_err = 0; r_stall = 0; r_rd = 0; r_wr = 0; r_wrcyc = 0;
        for (int c = 1; c <= 8; c++) begin
            if (r_done == 0) begin
                @(negedge clk);
                if (stall) r_stall++;
                if (misalign_err) r_err++;
                if (dm_MemRead) r_rd++;
                if (dm_MemWrite) begin r_wr++; r_wrcyc = c; end
                if (done) r_done = c;
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 7'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", misalign_err); end
        n_cmp++; if (dm_MemRead !== 1'b0 || dm_MemWrite !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ctl: got rd=%b wr=%b want 0 0", dm_MemRead, dm_MemWrite); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
        n_cmp++; if (dm_R_addr !== 7'h0 || dm_W_data !== 32'h0) begin n_fail++; $display("FAIL reset_regs: got addr=%h wdata=%h want 0 0", dm_R_addr, dm_W_data); end
        preload = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_word_load;
        run_req(1'b0, 2'b10, 1'b0, 7'h04, 32'h0);
        n_cmp++; if (r_done !== 3) begin n_fail++; $display("FAIL wload_done_cycle: got %0d want 3", r_done); end
        n_cmp++; if (r_stall !== 2) begin n_fail++; $display("FAIL wload_stall_cycles: got %0d want 2", r_stall); end
        n_cmp++; if (rdata !== 32'h0000000A) begin n_fail++; $display("FAIL wload_rdata: got %h want 0000000a", rdata); end
        n_cmp++; if (r_rd !== 1 || r_wr !== 0 || r_err !== 0) begin n_fail++; $display("FAIL wload_ctl: got rd=%0d wr=%0d err=%0d want 1 0 0", r_rd, r_wr, r_err); end
    endtask

    task automatic test_misaligned;
        run_req(1'b0, 2'b10, 1'b0, 7'h06, 32'h0);
        n_cmp++; if (r_done !== 2) begin n_fail++; $display("FAIL mis_word_done_cycle: got %0d want 2", r_done); end
        n_cmp++; if (r_err !== 1) begin n_fail++; $display("FAIL mis_word_err: got %0d cycles want 1", r_err); end
        n_cmp++; if (r_rd !== 0 || r_wr !== 0) begin n_fail++; $display("FAIL mis_word_access: got rd=%0d wr=%0d want 0 0", r_rd, r_wr); end
        n_cmp++; if (rdata !== 32'h0000000A) begin n_fail++; $display("FAIL mis_word_rdata_hold: got %h want 0000000a", rdata); end
        run_req(1'b1, 2'b01, 1'b0, 7'h01, 32'hCAFE);
        n_cmp++; if (r_done !== 2 || r_err !== 1 || r_wr !== 0) begin n_fail++; $display("FAIL mis_half_store: got done=%0d err=%0d wr=%0d want 2 1 0", r_done, r_err, r_wr); end
        n_cmp++; if (mem[0] !== 32'h0) begin n_fail++; $display("FAIL mis_half_mem: got %h want 00000000", mem[0]); end
        run_req(1'b0, 2'b11, 1'b0, 7'h00, 32'h0);
        n_cmp++; if (r_done !== 2 || r_err !== 1 || r_rd !== 0) begin n_fail++; $display("FAIL mis_size11: got done=%0d err=%0d rd=%0d want 2 1 0", r_done, r_err, r_rd); end
    endtask

    task automatic test_subword_load;
`ifdef LSU_SUBWORD_EN
        run_req(1'b0, 2'b00, 1'b1, 7'h08, 32'h0);
        n_cmp++; if (r_done !== 3 || rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed: got done=%0d rdata=%h want 3 ffffff80", r_done, rdata); end
        run_req(1'b0, 2'b00, 1'b0, 7'h08, 32'h0);
        n_cmp++; if (rdata !== 32'h00000080) begin n_fail++; $display("FAIL lb_unsigned: got %h want 00000080", rdata); end
        run_req(1'b0, 2'b01, 1'b1, 7'h0A, 32'h0);
        n_cmp++; if (r_done !== 3 || rdata !== 32'h00001234) begin n_fail++; $display("FAIL lh_signed_hi: got done=%0d rdata=%h want 3 00001234", r_done, rdata); end
        run_req(1'b0, 2'b00, 1'b1, 7'h0F, 32'h0);
        n_cmp++; if (rdata !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_lane3: got %h want ffffffaa", rdata); end
        run_req(1'b0, 2'b01, 1'b1, 7'h0C, 32'h0);
        n_cmp++; if (rdata !== 32'hFFFFCCDD) begin n_fail++; $display("FAIL lh_signed_lo: got %h want ffffccdd", rdata); end
`else
        run_req(1'b0, 2'b00, 1'b1, 7'h08, 32'h0);
        n_cmp++; if (r_done !== 2 || r_err !== 1 || r_rd !== 0) begin n_fail++; $display("FAIL lb_rejected: got done=%0d err=%0d rd=%0d want 2 1 0", r_done, r_err, r_rd); end
        n_cmp++; if (rdata !== 32'h0000000A) begin n_fail++; $display("FAIL lb_rejected_rdata: got %h want 0000000a", rdata); end
`endif
    endtask

    task automatic test_subword_store;
`ifdef LSU_SUBWORD_EN
        run_req(1'b1, 2'b00, 1'b0, 7'h0D, 32'hFFFFFF11);
        n_cmp++; if (r_done !== 4) begin n_fail++; $display("FAIL sb_done_cycle: got %0d want 4", r_done); end
        n_cmp++; if (r_wr !== 1 || r_wrcyc !== 3) begin n_fail++; $display("FAIL sb_write_pulse: got n=%0d cyc=%0d want 1 3", r_wr, r_wrcyc); end
        n_cmp++; if (mem[3] !== 32'hAABB11DD) begin n_fail++; $display("FAIL sb_mem: got %h want aabb11dd", mem[3]); end
        run_req(1'b1, 2'b01, 1'b0, 7'h0E, 32'h1234BEEF);
        n_cmp++; if (r_done !== 4 || mem[3] !== 32'hBEEF11DD) begin n_fail++; $display("FAIL sh_mem: got done=%0d mem=%h want 4 beef11dd", r_done, mem[3]); end
`else
        run_req(1'b1, 2'b00, 1'b0, 7'h0D, 32'hFFFFFF11);
        n_cmp++; if (r_done !== 2 || r_err !== 1 || r_wr !== 0) begin n_fail++; $display("FAIL sb_rejected: got done=%0d err=%0d wr=%0d want 2 1 0", r_done, r_err, r_wr); end
        n_cmp++; if (mem[3] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL sb_rejected_mem: got %h want aabbccdd", mem[3]); end
`endif
    endtask

    task automatic test_reset_mid_store;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 7'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        n_cmp++; if (dm_MemWrite !== 1'b1) begin n_fail++; $display("FAIL rst_store_write_on: got %b want 1", dm_MemWrite); end
        #1;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        n_cmp++; if (dm_MemWrite !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_store_drop: got wr=%b done=%b want 0 0", dm_MemWrite, done); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_store_rdata_clr: got %h want 00000000", rdata); end
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (mem[4] !== 32'h12121212) begin n_fail++; $display("FAIL rst_store_mem: got %h want 12121212", mem[4]); end
        run_req(1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
        n_cmp++; if (r_done !== 3 || rdata !== 32'h12121212) begin n_fail++; $display("FAIL rst_store_idle: got done=%0d rdata=%h want 3 12121212", r_done, rdata); end
    endtask

    task automatic test_back_to_back;
        run_req(1'b1, 2'b10, 1'b0, 7'h14, 32'h00000005);
        n_cmp++; if (r_done !== 3 || r_wr !== 1 || r_wrcyc !== 2) begin n_fail++; $display("FAIL b2b_store: got done=%0d wr=%0d cyc=%0d want 3 1 2", r_done, r_wr, r_wrcyc); end
        run_req(1'b0, 2'b10, 1'b0, 7'h14, 32'h0);
        n_cmp++; if (r_done !== 3) begin n_fail++; $display("FAIL b2b_load_accept: got done cycle %0d want 3", r_done); end
        n_cmp++; if (rdata !== 32'h00000005) begin n_fail++; $display("FAIL b2b_load_rdata: got %h want 00000005", rdata); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_misaligned();
        test_subword_load();
        test_subword_store();
        test_reset_mid_store();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
